gerenciador_alarme_temperatura: RTL and testbench
=================================================

// Module: gerenciador_alarme_temperatura
// PURPOSE
//  Consumes the temperature alarm level (alarmeSonoroTemperatura) from the temperature control system.
//  Latches each alarm event, drives siren and lamp annunciation, and takes operator acknowledge/rearm.
//  Escalates to a latched reactor shutdown request if an alarm stays unacknowledged too long.
//  Sits between the temperature control system and the control-room panel / reactor protection logic.
// PARAMETERS
//  PULSO_CICLOS   25_000_000  clk cycles per siren/lamp half-period (beep phase toggle)
//  ESCALA_PULSOS  60          phase toggles in ATIVO before shutdown (default 30 s at 50 MHz)
//  CONT_W         32          width of the cycle counter; must hold PULSO_CICLOS-1
// PORTS
//  clk                      in   1  system clock; single clock domain
//  rst                      in   1  synchronous, active-high reset
//  alarmeSonoroTemperatura  in   1  alarm level from temperature control system, same clk domain
//  botaoReconhecer          in   1  operator acknowledge button, asynchronous level
//  botaoRearmar             in   1  operator rearm/clear button, asynchronous level
//  sirene                   out  1  siren drive
//  luzAlarme                out  1  panel lamp drive
//  desligamentoReator       out  1  latched shutdown (SCRAM) request to reactor protection
//  estadoAlarme             out  2  current FSM state (encoding below)
// BEHAVIOUR
//  Reset: state NORMAL; all counters, phase, edge and sync registers 0; all outputs 0.
//  Input path:
//   - alarmeSonoroTemperatura registered once (alarmeReg); alarmeReg rises -> state changes next edge.
//   - Buttons: 2-FF synchronizer, then rising-edge pulse.
//   - Pulse is 1 cycle; counts 3 edges after the level is sampled. Held buttons act once.
//  State register (estadoAlarme):
//   - NORMAL=00 ; ATIVO=01 ; RECONHECIDO=10 ; SCRAM=11.
//   - Outputs decode combinationally from state and fase; no extra latency.
//  Transitions, evaluated every edge:
//   - NORMAL: alarmeReg=1 -> ATIVO; clear cycle counter, fase, escalation counter.
//   - ATIVO: stays latched even if alarmeReg drops; rearm pulse ignored.
//     - Escalation counter reaches ESCALA_PULSOS -> SCRAM.
//     - Otherwise, acknowledge pulse -> RECONHECIDO.
//     - Escalation and acknowledge in the same cycle -> SCRAM (safety wins).
//   - RECONHECIDO:
//     - Rising edge of alarmeReg (new event after a drop) -> ATIVO; counters cleared.
//     - Rearm pulse with alarmeReg=0 -> NORMAL.
//     - Rearm pulse with alarmeReg=1 -> ignored.
//     - Rising edge and rearm in the same cycle -> ATIVO.
//   - SCRAM: absorbing; only rst leaves it. Acknowledge and rearm ignored.
//  Timing (ATIVO only; counters frozen at 0 in every other state):
//   - Cycle counter 0..PULSO_CICLOS-1 wraps; on wrap, fase toggles and escalation counter +1.
//   - Escalation counter saturates at ESCALA_PULSOS.
//  Outputs per state:
//   - NORMAL:      sirene=0,    luz=0,    deslig=0
//   - ATIVO:       sirene=fase, luz=fase, deslig=0
//   - RECONHECIDO: sirene=0,    luz=1,    deslig=0
//   - SCRAM:       sirene=1,    luz=1,    deslig=1
//  Reset mid-operation, including in SCRAM: next edge equals the post-reset state; the alarm is re-detected.
//  Widths: counters unsigned. Escalation counter is $clog2(ESCALA_PULSOS+1) bits. No overflow possible.
// STRUCTURE
//  Shared package/include (alarme_pkg): state localparams NORMAL/ATIVO/RECONHECIDO/SCRAM, 2-bit width.
//  Sub-module sincronizador_botao: 2-FF sync plus rising-edge pulse; instantiated for each button.
//  Top: single FSM always block, counter block, output decode.
// TESTING (bench params PULSO_CICLOS=4, ESCALA_PULSOS=6)
//  1. rst 2 cycles, inputs 0 -> all outputs 0, estadoAlarme=00; holds for 20 cycles.
//  2. Alarm high, then low after 3 cycles -> estado=01 two edges later; sirene toggles every 4 cycles; stays 01.
//  3. In ATIVO, pulse botaoReconhecer -> estado=10 three edges later, sirene=0, luz=1.
//     Rearm with alarm high -> stays 10. Drop alarm, then rearm -> 00.
//  4. Alarm unacked -> estado=11 after 24 cycles in ATIVO; deslig=1.
//     Buttons ignored; only rst returns to 00.
//  5. Ack pulse timed to land on the 6th toggle -> estado=11, not 10.
//  6. RECONHECIDO, alarm drops then re-rises -> estado=01, counters restart. Held botaoReconhecer acts once.

Source files
------------

// File: rtl/alarme_pkg.sv
// Shared state encoding and output decode for the temperature alarm manager.
package alarme_pkg;

  localparam int unsigned EstadoW = 2;

  typedef enum logic [EstadoW-1:0] {
    StNormal      = 2'b00,
    StAtivo       = 2'b01,
    StReconhecido = 2'b10,
    StScram       = 2'b11
  } estado_e;

  typedef struct packed {
    logic sirene;
    logic luz;
    logic deslig;
  } saidas_t;

  // Annunciation per state; fase only matters while the alarm is active.
  function automatic saidas_t decodifica_saidas(estado_e estado, logic fase);
    saidas_t s;
    s = '0;
    unique case (estado)
      StNormal:      s = '{sirene: 1'b0, luz: 1'b0, deslig: 1'b0};
      StAtivo:       s = '{sirene: fase, luz: fase, deslig: 1'b0};
      StReconhecido: s = '{sirene: 1'b0, luz: 1'b1, deslig: 1'b0};
      StScram:       s = '{sirene: 1'b1, luz: 1'b1, deslig: 1'b1};
      default:       s = '{sirene: 1'b1, luz: 1'b1, deslig: 1'b1};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sincronizador_botao.sv
// Two-flop synchronizer for an asynchronous button, followed by a one-cycle rising-edge pulse.
module sincronizador_botao (
  input  logic clk_i,
  input  logic rst_i,
  input  logic botao_i,
  output logic pulso_o
);

  logic sinc1_q, sinc2_q, anterior_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sinc1_q    <= 1'b0;
      sinc2_q    <= 1'b0;
      anterior_q <= 1'b0;
    end else begin
      sinc1_q    <= botao_i;
      sinc2_q    <= sinc1_q;
      anterior_q <= sinc2_q;
    end
  end

  // A held button yields a single pulse.
  assign pulso_o = sinc2_q & ~anterior_q;

endmodule

// File: rtl/gerenciador_alarme_temperatura.sv
// Latches temperature alarms, drives siren/lamp, handles ack/rearm and escalates to SCRAM.
module gerenciador_alarme_temperatura
  import alarme_pkg::*;
#(
  parameter int unsigned PULSO_CICLOS  = 25_000_000,
  parameter int unsigned ESCALA_PULSOS = 60,
  parameter int unsigned CONT_W        = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alarmeSonoroTemperatura,
  input  logic         botaoReconhecer,
  input  logic         botaoRearmar,
  output logic         sirene,
  output logic         luzAlarme,
  output logic         desligamentoReator,
  output logic [1:0]   estadoAlarme
);

  localparam int unsigned EscW = $clog2(ESCALA_PULSOS + 1);
  localparam logic [CONT_W-1:0] ContMax = CONT_W'(PULSO_CICLOS - 1);
  localparam logic [EscW-1:0]   EscMax  = EscW'(ESCALA_PULSOS);

  logic alarme_q, alarme_ant_q;
  logic alarme_sobe;
  logic reconhecer_pulso, rearmar_pulso;

  estado_e           estado_q, estado_d;
  logic [CONT_W-1:0] cont_q, cont_d;
  logic              fase_q, fase_d;
  logic [EscW-1:0]   esc_q, esc_d, esc_inc;
  logic              volta, escala_atinge;
  saidas_t           saidas;

  always_ff @(posedge clk) begin
    if (rst) begin
      alarme_q     <= 1'b0;
      alarme_ant_q <= 1'b0;
    end else begin
      alarme_q     <= alarmeSonoroTemperatura;
      alarme_ant_q <= alarme_q;
    end
  end

  assign alarme_sobe = alarme_q & ~alarme_ant_q;

  sincronizador_botao u_sinc_reconhecer (
    .clk_i   (clk),
    .rst_i   (rst),
    .botao_i (botaoReconhecer),
    .pulso_o (reconhecer_pulso)
  );

  sincronizador_botao u_sinc_rearmar (
    .clk_i   (clk),
    .rst_i   (rst),
    .botao_i (botaoRearmar),
    .pulso_o (rearmar_pulso)
  );

  assign volta   = (estado_q == StAtivo) && (cont_q == ContMax);
  assign esc_inc = (esc_q == EscMax) ? esc_q : esc_q + EscW'(1);
  // Escalation fires on the very edge the counter reaches its limit.
  assign escala_atinge = (estado_q == StAtivo) &&
                         ((esc_q == EscMax) || (volta && (esc_inc == EscMax)));

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      StNormal: begin
        if (alarme_q) estado_d = StAtivo;
      end
      StAtivo: begin
        if (escala_atinge)         estado_d = StScram;
        else if (reconhecer_pulso) estado_d = StReconhecido;
      end
      StReconhecido: begin
        if (alarme_sobe)                    estado_d = StAtivo;
        else if (rearmar_pulso && !alarme_q) estado_d = StNormal;
      end
      StScram: estado_d = StScram;
      default: estado_d = StScram;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) estado_q <= StNormal;
    else     estado_q <= estado_d;
  end

  // Counters only run while staying in ATIVO; any entry into ATIVO starts from zero.
  always_comb begin
    cont_d = '0;
    fase_d = 1'b0;
    esc_d  = '0;
    if ((estado_q == StAtivo) && (estado_d == StAtivo)) begin
      if (volta) begin
        cont_d = '0;
        fase_d = ~fase_q;
        esc_d  = esc_inc;
      end else begin
        cont_d = cont_q + CONT_W'(1);
        fase_d = fase_q;
        esc_d  = esc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cont_q <= '0;
      fase_q <= 1'b0;
      esc_q  <= '0;
    end else begin
      cont_q <= cont_d;
      fase_q <= fase_d;
      esc_q  <= esc_d;
    end
  end

  assign saidas             = decodifica_saidas(estado_q, fase_q);
  assign sirene             = saidas.sirene;
  assign luzAlarme          = saidas.luz;
  assign desligamentoReator = saidas.deslig;
  assign estadoAlarme       = estado_q;

endmodule

// File: tb/tb_gerenciador_alarme_temperatura.sv
// Scoreboard bench: stimulus queues expected outputs per clock edge, a monitor compares them.
module tb_gerenciador_alarme_temperatura;

  logic       clk = 1'b0;
  logic       rst;
  logic       alarme, reconhecer, rearmar;
  logic       sirene, luz, deslig;
  logic [1:0] estado;

  gerenciador_alarme_temperatura #(
    .PULSO_CICLOS  (4),
    .ESCALA_PULSOS (6),
    .CONT_W        (32)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .alarmeSonoroTemperatura (alarme),
    .botaoReconhecer         (reconhecer),
    .botaoRearmar            (rearmar),
    .sirene                  (sirene),
    .luzAlarme               (luz),
    .desligamentoReator      (deslig),
    .estadoAlarme            (estado)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned borda;
    logic [1:0]  est;
    logic        sir;
    logic        lz;
    logic        des;
    string       nome;
  } esperado_t;

  esperado_t   sb[$];
  int unsigned n_bordas = 0;
  int          checks = 0;
  int          erros = 0;

  always @(posedge clk) n_bordas <= n_bordas + 1;

  // Monitor: compare every queued expectation whose edge has been reached.
  always @(negedge clk) begin
    int i;
    esperado_t e;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].borda <= n_bordas) begin
        e = sb[i];
        sb.delete(i);
        checks++;
        if (estado !== e.est || sirene !== e.sir || luz !== e.lz || deslig !== e.des) begin
          erros++;
          $display("FAIL %s @edge %0d: got est=%b sir=%b luz=%b desl=%b, want est=%b sir=%b luz=%b desl=%b",
                   e.nome, e.borda, estado, sirene, luz, deslig, e.est, e.sir, e.lz, e.des);
        end
      end else begin
        i++;
      end
    end
  end

  task automatic espera(input int unsigned k, input logic [1:0] est, input logic s,
                        input logic l, input logic d, input string nome);
    esperado_t e;
    e.borda = n_bordas + k;
    e.est   = est;
    e.sir   = s;
    e.lz    = l;
    e.des   = d;
    e.nome  = nome;
    sb.push_back(e);
  endtask

  task automatic passo(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; alarme = 1'b0; reconhecer = 1'b0; rearmar = 1'b0;
    passo(2);
    checks++;
    if (estado !== 2'b00 || sirene !== 1'b0 || luz !== 1'b0 || deslig !== 1'b0) begin
      erros++;
      $display("FAIL in_reset: got est=%b sir=%b luz=%b desl=%b, want all 0",
               estado, sirene, luz, deslig);
    end
    rst = 1'b0;

    // 1: idle after reset
    for (int k = 1; k <= 20; k++) espera(k, 2'b00, 0, 0, 0, "reset_idle");
    passo(20);
    checks++;
    if (estado !== 2'b00 || sirene !== 1'b0 || luz !== 1'b0 || deslig !== 1'b0) begin
      erros++;
      $display("FAIL idle_end: got est=%b sir=%b luz=%b desl=%b, want all 0",
               estado, sirene, luz, deslig);
    end

    // 2: alarm latches, siren blinks every 4 cycles
    alarme = 1'b1;
    espera(1, 2'b00, 0, 0, 0, "alarm_latency");
    espera(2, 2'b01, 0, 0, 0, "ativo_entry");
    espera(5, 2'b01, 0, 0, 0, "fase0_end");
    espera(6, 2'b01, 1, 1, 0, "fase1_start");
    espera(9, 2'b01, 1, 1, 0, "fase1_end");
    espera(10, 2'b01, 0, 0, 0, "fase0_again");
    passo(3);
    alarme = 1'b0;
    passo(7);

    // 3: acknowledge, rearm ignored while alarm high, rearm after drop
    alarme = 1'b1; reconhecer = 1'b1;
    espera(2, 2'b01, 0, 0, 0, "ack_latency");
    espera(3, 2'b10, 0, 1, 0, "ack_reconhecido");
    passo(1);
    reconhecer = 1'b0;
    passo(4);
    rearmar = 1'b1;
    espera(3, 2'b10, 0, 1, 0, "rearm_alarm_high");
    espera(5, 2'b10, 0, 1, 0, "rearm_alarm_high_hold");
    passo(1);
    rearmar = 1'b0;
    passo(5);
    alarme = 1'b0;
    passo(2);
    rearmar = 1'b1;
    espera(2, 2'b10, 0, 1, 0, "rearm_latency");
    espera(3, 2'b00, 0, 0, 0, "rearm_normal");
    passo(1);
    rearmar = 1'b0;
    passo(4);

    // 4: escalation to SCRAM, buttons ignored, reset re-detects alarm
    alarme = 1'b1;
    espera(24, 2'b01, 1, 1, 0, "pre_scram_24");
    espera(25, 2'b01, 1, 1, 0, "pre_scram_25");
    espera(26, 2'b11, 1, 1, 1, "scram");
    passo(28);
    checks++;
    if (estado !== 2'b11 || sirene !== 1'b1 || luz !== 1'b1 || deslig !== 1'b1) begin
      erros++;
      $display("FAIL scram_direct: got est=%b sir=%b luz=%b desl=%b, want est=11 all 1",
               estado, sirene, luz, deslig);
    end
    reconhecer = 1'b1; rearmar = 1'b1;
    passo(1);
    reconhecer = 1'b0; rearmar = 1'b0;
    espera(7, 2'b11, 1, 1, 1, "scram_absorbing");
    passo(8);
    rst = 1'b1;
    espera(1, 2'b00, 0, 0, 0, "scram_reset");
    espera(2, 2'b00, 0, 0, 0, "reset_redetect_lat");
    espera(3, 2'b01, 0, 0, 0, "reset_redetect");
    passo(1);
    rst = 1'b0;
    passo(3);
    alarme = 1'b0; rst = 1'b1;
    espera(1, 2'b00, 0, 0, 0, "reset_from_ativo");
    passo(1);
    rst = 1'b0;
    passo(2);

    // 5: ack on the sixth toggle loses to escalation
    alarme = 1'b1;
    passo(23);
    reconhecer = 1'b1;
    espera(2, 2'b01, 1, 1, 0, "race_pre");
    espera(3, 2'b11, 1, 1, 1, "race_scram_wins");
    passo(1);
    reconhecer = 1'b0;
    passo(4);
    alarme = 1'b0; rst = 1'b1;
    espera(1, 2'b00, 0, 0, 0, "reset_after_race");
    passo(1);
    rst = 1'b0;
    passo(2);

    // 6: held ack, new event from RECONHECIDO restarts counters
    alarme = 1'b1;
    passo(4);
    reconhecer = 1'b1;
    espera(2, 2'b01, 1, 1, 0, "held_pre_ack");
    espera(3, 2'b10, 0, 1, 0, "held_ack");
    passo(4);
    alarme = 1'b0;
    passo(3);
    alarme = 1'b1;
    espera(1, 2'b10, 0, 1, 0, "rerise_latency");
    espera(2, 2'b01, 0, 0, 0, "rerise_ativo");
    espera(5, 2'b01, 0, 0, 0, "restart_fase0");
    espera(6, 2'b01, 1, 1, 0, "restart_fase1");
    espera(9, 2'b01, 1, 1, 0, "held_no_reack");
    passo(10);
    reconhecer = 1'b0;
    alarme = 1'b0;

    passo(5);
    while (sb.size() > 0) begin
      erros++;
      $display("FAIL %s: expectation for edge %0d never checked, required none pending",
               sb[0].nome, sb[0].borda);
      void'(sb.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, erros);
    $finish;
  end

endmodule
